// File: rtl/mult16_seq.sv
// Purpose : iterative 16x16 shift-and-add multiplier built around a 16-bit carry-lookahead adder.
// Latency : product on the 17th edge after the accept edge (18th for a negative signed result).
// Backpr. : no queueing; start is sampled only in IDLE, the pipeline stalls on busy.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   start  operation request, sampled only in IDLE
//   a, b   multiplicand / multiplier, captured on the accept edge
//   busy   high while the datapath iterates (RUN, NEG)
//   done   one-cycle pulse; prod is valid in this cycle
//   prod   32-bit product, held until the next result overwrites it
//
// Build option: define MULT_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied and an extra NEG cycle negates the result).

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Carries into bits 1..4 of a 4-bit group, fully expanded.
  function automatic logic [3:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] cin_bit;
  logic [3:0]  c0;
  logic [3:0]  c1;
  logic [3:0]  c2;
  logic [3:0]  c3;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate / propagate.
  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  // Second-level lookahead: group carries without rippling through groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
                 (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
                 (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign c0 = grp_carry(g[3:0],   p[3:0],   gc[0]);
  assign c1 = grp_carry(g[7:4],   p[7:4],   gc[1]);
  assign c2 = grp_carry(g[11:8],  p[11:8],  gc[2]);
  assign c3 = grp_carry(g[15:12], p[15:12], gc[3]);

  assign cin_bit = {c3[2:0], gc[3], c2[2:0], gc[2], c1[2:0], gc[1], c0[2:0], gc[0]};
  assign sum     = p ^ cin_bit;
  assign cout    = gc[4];

endmodule

module mult16_seq #(
  parameter int N_BITS = 16  // must stay 16: the datapath is tied to cla16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   prod
);

`ifdef MULT_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, NEG = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [15:0] mcand;
  logic [31:0] acc;        // {acc_hi, acc_lo}
  logic [4:0]  count;
  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [31:0] acc_step;
  logic        run_last;

`ifdef MULT_SIGNED_EN
  logic        neg;
  // |-32768| wraps back to 16'h8000, which is correct when read as unsigned.
  assign a_mag = a[15] ? (~a + 16'd1) : a;
  assign b_mag = b[15] ? (~b + 16'd1) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Partial-product accumulate: add mcand into the high half when the
  // current multiplier bit is set, then shift the 33-bit {cout,sum,lo} right.
  assign add_b = acc[0] ? mcand : 16'h0;

  cla16 u_add (
    .a    (acc[31:16]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign acc_step = {add_cout, add_sum, acc[15:1]};

  // Counts 0..15 are accumulate cycles; count 16 is the hand-off cycle
  // in which the finished accumulator is copied to prod.
  assign run_last = count[4];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (run_last) begin
`ifdef MULT_SIGNED_EN
          state_nxt = neg ? NEG : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= 16'h0;
      acc   <= 32'h0;
      count <= 5'd0;
      prod  <= 32'h0;
`ifdef MULT_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            acc   <= {16'h0, b_mag};
            count <= 5'd0;
`ifdef MULT_SIGNED_EN
            neg   <= a[15] ^ b[15];
`endif
          end
        end
        RUN: begin
          if (!run_last) begin
            acc   <= acc_step;
            count <= count + 5'd1;
          end else begin
`ifdef MULT_SIGNED_EN
            if (!neg) prod <= acc;
`else
            prod <= acc;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        NEG: prod <= ~acc + 32'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule
